uart_tx_framer: RTL
===================

# uart_tx_framer

- Serial transmitter that consumes the one-cycle baud tick from the 50 MHz baud divider (1 pulse per 5209 clk cycles, ≈9600 baud).
- Buffers bytes from the LC-3 side in a small FIFO through a valid/ready handshake, then shifts each byte out LSB-first as a standard UART frame: start bit, data bits, optional parity, stop bit.
- Sits directly downstream of the baud divider; `tx` drives the board's serial pin.

## Interface
Parameters:
- DATA_BITS, 8, data bits per frame.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW (4).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset: asynchronous, active-low. Clock is clk.
- baud_tick  in  1  one-clk pulse marking each bit boundary; arbitrary spacing ≥ 2 clk.
- tx_data  in  DATA_BITS  byte to send.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  FIFO can accept; equals !full.
- tx  out  1  serial line, idle high, registered.
- busy  out  1  high whenever the framer is not in IDLE.
- fifo_count  out  FIFO_AW+1  number of entries in the FIFO, 0..2**FIFO_AW.

## Operation
- Push: on a clk edge where tx_valid && tx_ready, tx_data is written at wr_ptr.
  - With tx_ready low, tx_valid is ignored. Data is not held for later.
- Pop: the framer reads FIFO head into the shift register when leaving IDLE or STOP toward START.
- Same-cycle push and pop: both happen; fifo_count is unchanged.
- Pointers wrap modulo depth. Full/empty come from fifo_count. The pop decision uses the registered count only, so a byte pushed in a tick cycle is not popped that cycle.
- Framer FSM. All transitions occur only on clk edges where baud_tick = 1:
  - IDLE: tx=1. If fifo_count≠0 → START, pop.
  - START: tx=0. → DATA, bit_idx=0.
  - DATA: tx=shift[0]. Shift right and increment bit_idx. After bit DATA_BITS-1 → PARITY if enabled, else STOP.
  - PARITY: tx=even parity (XOR of the byte). → STOP.
  - STOP: tx=1. If fifo_count≠0 → START with pop (back-to-back, no idle bit). Else → IDLE.
- Frame width in bits: DATA_BITS + 2, plus 1 with parity.
- Reset values: tx=1, busy=0, tx_ready=1, fifo_count=0, state=IDLE, pointers=0, shift register=0.
- Reset mid-frame aborts immediately: tx returns to 1 asynchronously and FIFO contents are discarded.

## Timing
- Each bit occupies exactly one baud_tick period.
- tx updates on the clk edge at which baud_tick is sampled high, i.e. 1 clk after the tick cycle begins.
- Latency from push into an empty FIFO while IDLE to the start bit: start bit appears at the first baud_tick edge strictly after the push edge.
- tx_ready falls on the edge that makes fifo_count = depth. It rises on the pop edge that frees an entry.
- busy rises with the start bit. It falls on the edge that ends the stop bit when the FIFO is empty.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state is included and frames are 11 bits with 8 data bits (even parity).
- UART_TX_PARITY_EN undefined: no PARITY state and frames are 10 bits (8N1).
- The port list is identical in both builds.

## Test plan
Tick every 4 clk; default parameters, parity off unless noted.
- Single byte: push 0x55 → tx sequence 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), one bit per tick. busy high for 10 ticks. fifo_count 1→0 at the start bit.
- Back-to-back: push 0xA0, 0x0F → two 10-bit frames with no idle bit between them. Second start bit immediately follows the first stop bit.
- Full FIFO: hold tx_valid with 0x01..0x06 while IDLE and before the first tick.
  - Required: 4 accepted, tx_ready=0 while count=4.
  - After the first pop, tx_ready=1 and 0x05 is accepted; 0x06 is accepted after the next pop.
  - Output order is 0x01..0x06.
- Push/pop collision: with count=2, push on the same edge as a pop → count stays 2. No byte lost or duplicated.
- Parity (UART_TX_PARITY_EN): push 0x07 → bits 0,1,1,1,0,0,0,0,0, parity 1, stop 1 (11 ticks).
- Reset mid-frame: assert rst_n low during DATA bit 3 of 0xC3 with 2 bytes queued.
  - Required: tx=1 and fifo_count=0 immediately.
  - After release, no frame is sent until a new push.

Source files
------------

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer with a small input FIFO
//
// Buffers bytes arriving through a valid/ready handshake and shifts each one
// out LSB-first as a UART frame: start bit, DATA_BITS data bits, optional even
// parity, one stop bit. Every bit lasts exactly one baud_tick period. Frames
// are sent back to back while the FIFO holds data.
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit after
// the data bits. The port list is the same in both builds.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   baud_tick   in   one-clk pulse at each bit boundary
//   tx_data     in   byte to send
//   tx_valid    in   tx_data valid
//   tx_ready    out  FIFO can accept a byte (not full)
//   tx          out  serial line, idle high, registered
//   busy        out  high whenever the framer is not idle
//   fifo_count  out  bytes currently held in the FIFO
module uart_tx_framer #(
  parameter int DATA_BITS = 8,
  parameter int FIFO_AW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [FIFO_AW:0]     fifo_count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [FIFO_AW:0]   CNT_FULL = DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0]   CNT_ONE  = 1;
  localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;
  localparam logic [IDX_W-1:0]   IDX_ONE  = 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [FIFO_AW-1:0]   r_wr_ptr;
  logic [FIFO_AW-1:0]   r_rd_ptr;
  logic [FIFO_AW:0]     r_count;

  // Framer state
  state_t               r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [IDX_W-1:0]     r_bit_idx;
  logic                 r_tx;
  logic                 r_busy;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic                 w_full;
  logic                 w_nonempty;
  logic                 w_push;
  logic                 w_pop;
  logic [DATA_BITS-1:0] w_head;

  assign w_full     = (r_count == CNT_FULL);
  assign w_nonempty = (r_count != '0);
  assign w_push     = tx_valid && !w_full;
  // The pop looks only at the registered count, so a byte written on a tick
  // edge is never popped on that same edge.
  assign w_pop      = baud_tick && w_nonempty &&
                      ((r_state == S_IDLE) || (r_state == S_STOP));
  assign w_head     = r_mem[r_rd_ptr];

  assign tx_ready   = !w_full;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign fifo_count = r_count;

  // Storage is not reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // tx is registered: each transition loads the line level of the state
  // being entered, so the line changes on the tick edge itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else if (baud_tick) begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_nonempty) begin
            r_state  <= S_START;
            r_shift  <= w_head;
            r_tx     <= 1'b0;
            r_busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^w_head;
`endif
          end
        end

        S_START: begin
          r_state   <= S_DATA;
          r_bit_idx <= '0;
          r_tx      <= r_shift[0];
          r_shift   <= r_shift >> 1;
        end

        S_DATA: begin
          if (r_bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            r_state <= S_PARITY;
            r_tx    <= r_parity;
`else
            r_state <= S_STOP;
            r_tx    <= 1'b1;
`endif
          end else begin
            r_bit_idx <= r_bit_idx + IDX_ONE;
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          r_state <= S_STOP;
          r_tx    <= 1'b1;
        end
`endif

        S_STOP: begin
          if (w_nonempty) begin
            // Back-to-back frame: next start bit follows the stop bit directly.
            r_state  <= S_START;
            r_shift  <= w_head;
            r_tx     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^w_head;
`endif
          end else begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
